// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution, one-shot redirect and mispredict statistics
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_br,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    input  logic [32:0]      bp_to_ex_bus,
    output logic [32:0]      br_bus,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [31:0]      last_mis_pc,
    input  logic             stat_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        ex_bp_e;
    logic [31:0] ex_bp_target;
    logic        ex_stop;
    logic        live;
    logic        act_taken;
    logic        mis_t;
    logic        mis_n;
    logic        br_e;
    logic [31:0] fall_through;
    logic [31:0] br_target;
    logic        fired;
    logic        leave_ex;
    logic        unused_stall;

    assign ex_bp_e      = bp_to_ex_bus[32];
    assign ex_bp_target = bp_to_ex_bus[31:0];
    // Only the EX slot of the stall vector matters here.
    assign ex_stop      = stall[4];
    assign unused_stall = ^{stall[5], stall[3:0]};

    assign live         = ex_valid & ~flush;
    assign act_taken    = ex_is_br & ex_br_taken;
    assign fall_through = ex_pc + 32'd8;

    // Taken but not predicted, or predicted to the wrong place.
    assign mis_t = live & act_taken & (~ex_bp_e | (ex_bp_target != ex_br_target));
    // Predicted taken but the instruction falls through past its delay slot.
    assign mis_n = live & ex_bp_e & ~act_taken;

    // The guard keeps a stalled mispredict from re-issuing its redirect.
    assign br_e     = (mis_t | mis_n) & ~fired;
    assign leave_ex = live & ~ex_stop;

    // Redirect target, forced to zero whenever no request is raised.
    always_comb begin
        br_target = 32'b0;
        if (br_e) begin
            br_target = mis_t ? ex_br_target : fall_through;
        end
    end

    assign br_bus = {br_e, br_target};

    // One-shot guard: armed when a redirect fires under a hold, dropped once EX moves or flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fired <= 1'b0;
        end else if (!ex_stop || flush) begin
            fired <= 1'b0;
        end else if (br_e) begin
            fired <= 1'b1;
        end
    end

    // Saturating branch counter, bumped as a branch leaves EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt <= '0;
        end else if (stat_clr) begin
            br_cnt <= '0;
        end else if (leave_ex && ex_is_br && br_cnt != CNT_MAX) begin
            br_cnt <= br_cnt + 1'b1;
        end
    end

    // Saturating mispredict counter and PC of the latest mispredict, one update per redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_cnt     <= '0;
            last_mis_pc <= 32'b0;
        end else if (stat_clr) begin
            mis_cnt     <= '0;
            last_mis_pc <= 32'b0;
        end else if (br_e) begin
            last_mis_pc <= ex_pc;
            if (mis_cnt != CNT_MAX) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

    localparam int CNT_W = 4;
    localparam int CNT_MAXV = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_is_br;
    logic             ex_br_taken;
    logic [31:0]      ex_br_target;
    logic             bp_e;
    logic [31:0]      bp_t;
    logic [32:0]      bp_to_ex_bus;
    logic [32:0]      br_bus;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;
    logic [31:0]      last_mis_pc;
    logic             stat_clr;

    assign bp_to_ex_bus = {bp_e, bp_t};

    branch_resolve #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_is_br     (ex_is_br),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .bp_to_ex_bus (bp_to_ex_bus),
        .br_bus       (br_bus),
        .br_cnt       (br_cnt),
        .mis_cnt      (mis_cnt),
        .last_mis_pc  (last_mis_pc),
        .stat_clr     (stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference state: "already redirected for the resident instruction" plus statistics.
    bit          m_fired;
    int          m_br;
    int          m_mis;
    logic [31:0] m_last;

    typedef struct {
        string       name;
        logic        valid;
        logic        flsh;
        logic [31:0] pc;
        logic        is_br;
        logic        taken;
        logic [31:0] tgt;
        logic        bpe;
        logic [31:0] bpt;
        logic [32:0] exp_bus;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Redirect request derived from the prediction rules, not from the RTL structure.
    function automatic logic [32:0] model_bus();
        bit          live;
        bit          went;
        bit          req;
        logic [31:0] t;
        live = ex_valid && !flush;
        went = ex_is_br && ex_br_taken;
        req  = 0;
        t    = 32'b0;
        if (live && went && !(bp_e && bp_t == ex_br_target)) begin
            req = 1;
            t   = ex_br_target;
        end else if (live && !went && bp_e) begin
            req = 1;
            t   = ex_pc + 32'd8;
        end
        if (!req || m_fired) return 33'b0;
        return {1'b1, t};
    endfunction

    // One clock: starts at posedge+1, checks br_bus mid-cycle, advances model, checks stats after edge.
    task automatic cycle(input string tag);
        logic [32:0] eb;
        bit          stop;
        #3;
        eb = model_bus();
        check({tag, ".br_bus"}, {31'b0, br_bus}, {31'b0, eb});
        stop = stall[4];
        if (stat_clr) begin
            m_br = 0; m_mis = 0; m_last = 32'b0;
        end else begin
            if (ex_valid && !flush && !stop && ex_is_br && m_br < CNT_MAXV) m_br++;
            if (eb[32]) begin
                if (m_mis < CNT_MAXV) m_mis++;
                m_last = ex_pc;
            end
        end
        if (!stop || flush) m_fired = 0;
        else if (eb[32]) m_fired = 1;
        @(posedge clk);
        #1;
        check({tag, ".br_cnt"}, 64'(br_cnt), 64'(m_br));
        check({tag, ".mis_cnt"}, 64'(mis_cnt), 64'(m_mis));
        check({tag, ".last_mis_pc"}, 64'(last_mis_pc), 64'(m_last));
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] pc, input logic br,
                         input logic tk, input logic [31:0] tg, input logic be, input logic [31:0] bt);
        ex_valid = v; flush = f; ex_pc = pc; ex_is_br = br;
        ex_br_taken = tk; ex_br_target = tg; bp_e = be; bp_t = bt;
    endtask

    task automatic bubble();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        rst = 1'b0; stall = 6'b0; stat_clr = 1'b0;
        bubble();
        m_fired = 0; m_br = 0; m_mis = 0; m_last = 32'b0;

        vecs[0] = '{"taken_nopred",   1, 0, 32'h1000, 1, 1, 32'h2000, 0, 32'h0,    {1'b1, 32'h2000}};
        vecs[1] = '{"pred_nottaken",  1, 0, 32'h1000, 1, 0, 32'h2000, 1, 32'h2000, {1'b1, 32'h1008}};
        vecs[2] = '{"correct_taken",  1, 0, 32'h1000, 1, 1, 32'h2000, 1, 32'h2000, 33'b0};
        vecs[3] = '{"wrong_target",   1, 0, 32'h1100, 1, 1, 32'h2000, 1, 32'h3000, {1'b1, 32'h2000}};
        vecs[4] = '{"nonbr_nopred",   1, 0, 32'h0040, 0, 0, 32'h0,    0, 32'h0,    33'b0};
        vecs[5] = '{"nonbr_pred",     1, 0, 32'h0040, 0, 0, 32'h0,    1, 32'h0800, {1'b1, 32'h0048}};
        vecs[6] = '{"flush_kill",     1, 1, 32'h1000, 1, 1, 32'h2000, 0, 32'h0,    33'b0};
        vecs[7] = '{"bubble_pred",    0, 0, 32'h1000, 1, 0, 32'h0,    1, 32'h2000, 33'b0};
        vecs[8] = '{"pc_wrap",        1, 0, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 32'h10, {1'b1, 32'h0000_0004}};
        vecs[9] = '{"nonbr_takenbit", 1, 0, 32'h0200, 0, 1, 32'h0300, 0, 32'h0,   33'b0};

        // Reset state with bubble inputs.
        @(posedge clk); #1;
        check("reset.br_bus", {31'b0, br_bus}, 64'h0);
        check("reset.br_cnt", 64'(br_cnt), 64'h0);
        check("reset.mis_cnt", 64'(mis_cnt), 64'h0);
        check("reset.last_mis_pc", 64'(last_mis_pc), 64'h0);
        rst = 1'b1;

        // Table of single-cycle cases, no stall.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].flsh, vecs[i].pc, vecs[i].is_br, vecs[i].taken,
                  vecs[i].tgt, vecs[i].bpe, vecs[i].bpt);
            #2;
            check({vecs[i].name, ".tab"}, {31'b0, br_bus}, {31'b0, vecs[i].exp_bus});
            #0;
            cycle(vecs[i].name);
        end
        // Absolute values after table: branches 0,1,2,3,8 leave EX; mispredicts 0,1,3,5,8.
        check("table.br_cnt_abs", 64'(br_cnt), 64'd5);
        check("table.mis_cnt_abs", 64'(mis_cnt), 64'd5);
        check("table.last_abs", 64'(last_mis_pc), 64'hFFFF_FFFC);

        // Mispredict held three cycles by stall: fires once, counted once.
        stat_clr = 1; bubble(); cycle("clr0"); stat_clr = 0;
        drive(1, 0, 32'h1000, 1, 1, 32'h2000, 0, 32'h0);
        stall = 6'b010000;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("stall.br_e%0d", k), 64'(br_bus[32]), (k == 0) ? 64'd1 : 64'd0);
            #0;
            cycle("stall");
        end
        stall = 6'b0;
        cycle("release");
        check("stall.mis_once", 64'(mis_cnt), 64'd1);
        check("stall.br_once", 64'(br_cnt), 64'd1);
        bubble(); cycle("bubble");

        // Reset asserted mid-stall clears state at once; resident mispredict fires again after.
        drive(1, 0, 32'h1400, 1, 0, 32'h0, 1, 32'h1800);
        stall = 6'b010000;
        cycle("rs0");
        cycle("rs1");
        #2; rst = 1'b0; #1;
        check("async.mis_cnt", 64'(mis_cnt), 64'h0);
        check("async.br_cnt", 64'(br_cnt), 64'h0);
        check("async.last", 64'(last_mis_pc), 64'h0);
        m_fired = 0; m_br = 0; m_mis = 0; m_last = 32'b0;
        @(posedge clk); #1; rst = 1'b1;
        #2;
        check("async.refire", {31'b0, br_bus}, {31'b0, 1'b1, 32'h1408});
        #0;
        cycle("rs2");
        stall = 6'b0;
        cycle("rs3");
        bubble(); cycle("rs4");

        // Saturation: more mispredicts than the counter can hold.
        for (int k = 0; k < CNT_MAXV + 3; k++) begin
            drive(1, 0, 32'h3000 + 32'(k * 4), 0, 0, 32'h0, 1, 32'h5000);
            cycle("sat");
        end
        check("sat.mis_cnt", 64'(mis_cnt), 64'(CNT_MAXV));

        // Clear wins over a simultaneous mispredict.
        drive(1, 0, 32'h1000, 1, 1, 32'h2000, 0, 32'h0);
        stat_clr = 1;
        cycle("clr");
        stat_clr = 0;
        check("clr.mis_cnt", 64'(mis_cnt), 64'h0);
        check("clr.br_cnt", 64'(br_cnt), 64'h0);
        check("clr.last", 64'(last_mis_pc), 64'h0);

        // Randomized traffic: EX contents held while stalled, fresh otherwise.
        for (int k = 0; k < 400; k++) begin
            if (!stall[4] || $urandom_range(0, 5) == 0) begin
                drive($urandom_range(0, 4) != 0, 1'b0, {$urandom_range(0, 15), 2'b00} + 32'h100,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                      {$urandom_range(0, 3), 4'h0}, $urandom_range(0, 1), {$urandom_range(0, 3), 4'h0});
            end
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 2) == 0) ? 6'b010000 : 6'b0;
            stat_clr = ($urandom_range(0, 40) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves the branch in EX against the prediction carried from the predictor on `bp_to_ex_bus`, and drives the correction `br_bus` back to the predictor and the fetch stage. It sits in EX, beside the ALU branch-compare logic.
- It fires each redirect exactly once, even while EX is held by a downstream stall.
- It keeps saturating branch and mispredict counters for performance tuning.

## Interface
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in `StallBus`: pipeline stall vector. `stall[4]==Stop` holds the current EX instruction.
- `flush` in 1: exception/ERET flush; kills the EX instruction.
- `ex_valid` in 1: EX holds a real instruction, not a bubble.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_is_br` in 1: EX instruction is a branch or jump.
- `ex_br_taken` in 1: resolved direction (1 = taken); jumps are always 1.
- `ex_br_target` in 32: resolved target address.
- `bp_to_ex_bus` in `BR_WD` (33): {`ex_bp_e`, `ex_bp_target[31:0]`}, the prediction made for this instruction.
- `br_bus` out `BR_WD` (33): {`br_e`, `br_target[31:0]`}, the redirect and train request.
- `br_cnt` out `CNT_W`: count of branches retired from EX.
- `mis_cnt` out `CNT_W`: count of mispredicts.
- `last_mis_pc` out 32: `ex_pc` of the most recent mispredict.
- `stat_clr` in 1: synchronous clear of `br_cnt`, `mis_cnt` and `last_mis_pc`.

## Operation
- `live = ex_valid & ~flush`.
- Mispredict taken case: `mis_t = live & ex_is_br & ex_br_taken & (~ex_bp_e | ex_bp_target != ex_br_target)`. Correct target is `ex_br_target`.
- Mispredict not-taken case: `mis_n = live & ex_bp_e & ~(ex_is_br & ex_br_taken)`. Correct target is `ex_pc + 32'd8`, the fall-through past the delay slot; the adder wraps modulo 2^32.
- Combined: `mis = mis_t | mis_n`.
- `br_e = mis & ~fired`. `br_target = mis_t ? ex_br_target : (mis_n ? ex_pc+8 : 32'b0)`.
- `br_target` is 0 whenever `br_e = 0`.
- `fired` register, one-shot guard:
  - Set on an edge where `br_e & stall[4]==Stop`.
  - Cleared on any edge where `stall[4]==NoStop` or `flush`.
  - Set and clear in the same cycle is impossible by construction; clear has priority.
- An instruction "leaves EX" on an edge where `live & stall[4]==NoStop`.
- `br_cnt` increments by 1 when an instruction with `ex_is_br` leaves EX.
- `mis_cnt` increments by 1 on each edge where `br_e = 1`. Because of `fired`, each mispredict is counted once regardless of stall length.
- `last_mis_pc <= ex_pc` on each edge where `br_e = 1`.
- Both counters saturate at all-ones and never wrap.
- `stat_clr` has priority over increments on the same edge.
- Reset values (async, `rst = 0`): `fired = 0`, `br_cnt = 0`, `mis_cnt = 0`, `last_mis_pc = 0`. `br_bus` is therefore 0 while reset is applied, provided inputs are bubbles.
- Correct predictions drive no request: taken with matching target, or not-taken with no prediction. This means no BTB training, by design.

## Timing
- `br_bus` is combinational from EX inputs and `fired`; it is valid in the same cycle the branch occupies EX. The predictor flushes the front stages on the following edge.
- Counters and `last_mis_pc` reflect an event one edge after it occurs.
- `flush` forces `br_e = 0` in the same cycle and clears `fired` at the next edge.
- If reset is asserted mid-stall, all state clears immediately, and a still-resident mispredict re-fires after reset release.

## Test plan
1. Taken, not predicted:
   - Stimulus: `ex_pc=0x1000`, branch, taken, target `0x2000`, `bp_e=0`, no stall.
   - Response: `br_bus = {1, 0x2000}` the same cycle; next edge `mis_cnt=1`, `br_cnt=1`, `last_mis_pc=0x1000`.
2. Predicted taken, actually not taken:
   - Stimulus: `ex_pc=0x1000`, `bp_e=1`, `bp_target=0x2000`, `ex_br_taken=0`.
   - Response: `br_bus = {1, 0x1008}`.
3. Correct prediction:
   - Stimulus: `bp_e=1`, `bp_target=0x2000`, taken to `0x2000`.
   - Response: `br_bus = 0`; `br_cnt` increments, `mis_cnt` is unchanged.
4. Mispredict held by stall:
   - Stimulus: case 1 with `stall[4]=Stop` for 3 cycles, then released.
   - Response: `br_e=1` only in the first cycle; `mis_cnt=1`; `br_cnt` increments once, at release.
5. Flush and bubble suppression:
   - Stimulus: case 1 with `flush=1`; then `ex_valid=0` with `bp_e=1`.
   - Response: `br_bus = 0` in both cases, and no counter change.
6. Saturation, clear, wrap:
   - Force `mis_cnt` to all-ones and apply a mispredict: `mis_cnt` stays all-ones.
   - Apply `stat_clr` together with a mispredict: all statistics are 0 next edge.
   - `ex_pc=0xFFFFFFFC` with a not-taken mispredict: `br_target=0x00000004`.
